bit6_addsub_accumulator: RTL and testbench
==========================================

Name: bit6_addsub_accumulator

Overview:
- Sequential controller directly upstream and downstream of the 6-bit dataflow adder/subtractor (Bit6_Adder_Subtractor_DF).
- Accepts a stream of 6-bit operands, each with an add/sub select, over a valid/ready handshake. Drives the adder with {accumulator, operand, m} and captures CoBo/SD back into the accumulator.
- Presents the final chain result, flags and operand count on a valid/ready output port.
- Converts the purely combinational adder into a multi-operand running calculator.

Parameters:
- WIDTH, 6, operand/accumulator width; must match the adder instance.
- CNT_W, 6, operand-counter width; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  operand.
- in_op  in  1  0 = add, 1 = subtract (acc - in_data).
- in_first  in  1  beat starts a new chain.
- in_last  in  1  beat ends the chain.
- add_a  out  WIDTH  to adder a.
- add_b  out  WIDTH  to adder b.
- add_m  out  1  to adder m.
- add_cobo  in  1  adder carry/borrow.
- add_sd  in  WIDTH  adder sum/difference.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  final accumulator.
- out_cobo  out  1  CoBo of the last step.
- out_ovf  out  1  sticky two's-complement overflow over the chain.
- out_count  out  CNT_W  operands in the chain, saturating.

Behaviour:
- Reset is synchronous and active-high, applied on a clk edge with rst=1, and has priority over everything. After reset:
  - state=IDLE;
  - acc=0, cobo=0, ovf=0, count=0;
  - out_valid=0, in_ready=1.
  - Reset mid-chain or in HOLD discards all state with no output.
- States are IDLE, ACCUM and HOLD.
- in_ready=1 in IDLE and ACCUM, and 0 in HOLD. A beat is accepted on an edge where in_valid and in_ready are both 1.
- Adder drive is combinational from registers and inputs: add_a=acc, add_b=in_data, add_m=in_op.
- Adder convention: add_cobo is carry-out on add and borrow on subtract (1 when acc < in_data unsigned).
- First beat (any accepted beat in IDLE, or a beat with in_first=1 in any accepting state):
  - acc <= in_data; cobo <= 0; ovf <= 0; count <= 1.
  - in_op is ignored and the adder result is unused.
  - If in_first=1 arrives in ACCUM, the open chain is silently discarded and restarted.
- Continuation beat (ACCUM, in_first=0):
  - acc <= add_sd; cobo <= add_cobo; count <= count+1, saturating.
  - Overflow: ovf <= ovf | v.
    - Add: v=1 when acc[MSB]==in_data[MSB] and add_sd[MSB]!=acc[MSB].
    - Subtract: v=1 when acc[MSB]!=in_data[MSB] and add_sd[MSB]!=acc[MSB].
- Transitions:
  - An accepted beat with in_last=0 goes to ACCUM.
  - An accepted beat with in_last=1 goes to HOLD. out_valid rises on the next cycle, with outputs reflecting that final beat.
  - A beat with in_first=1 and in_last=1 is a single-operand chain.
- HOLD:
  - out_* hold stable while out_ready=0.
  - An edge with out_valid and out_ready both 1 goes to IDLE. out_valid=0 and in_ready=1 on the following cycle.
  - in_valid is ignored in HOLD.
  - There is no same-cycle accept in HOLD; one dead cycle per chain is accepted.
- out_result, out_cobo, out_ovf and out_count are registered copies of acc, cobo, ovf and count. They are meaningful only while out_valid=1 and hold their last value otherwise.
- All arithmetic is modulo 2^WIDTH and is performed only by the external adder. The block contains no internal adder except the count increment.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2;
  - OP_ADD=1'b0, OP_SUB=1'b1;
  - the WIDTH default.
- Natural sub-module: bit6_addsub_accumulator_top, which instantiates this block plus one Bit6_Adder_Subtractor_DF wired through the add_* ports. Verification runs on the top.

Test Plan:
- Reset: hold rst 2 cycles -> out_valid=0, in_ready=1, out_result=0, out_count=0; reassert rst mid-chain after 23 then +10 -> chain discarded, no out_valid.
- Chain 23 (first), +20 (last) -> out_result=43, out_cobo=0, out_ovf=1, out_count=2; out_valid exactly one cycle after the last accept.
- Chain 53 (first), -10 (last) -> out_result=43, out_cobo=0 (no borrow), out_ovf=0, out_count=2.
- Chain 56, +42, -40 (last) -> intermediate acc=34 with cobo=1; final out_result=58, out_cobo=1 (borrow), out_ovf=0, out_count=3.
- Backpressure: after chain 12 (first and last), hold out_ready=0 for 3 cycles -> out_result=12, count=1 stable and in_ready=0 with in_valid=1 ignored; out_ready=1 -> IDLE, in_ready=1 on the next cycle.
- Restart: 30 (first), +15, then 20 with in_first=1 and in_last=1 -> out_result=20, out_count=1, out_ovf=0.

Source files
------------

// File: rtl/bit6_addsub_accumulator_pkg.sv
// Shared types and constants for the 6-bit add/sub running accumulator.
// Holds the FSM encoding, the operation codes and a signed-overflow helper.
package bit6_addsub_accumulator_pkg;

  localparam int WIDTH_DEF = 6;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Subtract overflows when the operands differ in sign, add when they agree;
  // either way the result must have flipped away from the accumulator's sign.
  function automatic logic ovf_step(input logic op, input logic a_msb,
                                    input logic b_msb, input logic sd_msb);
    logic sign_cond;
    sign_cond = 1'b0;
    case (op)
      OP_ADD:  sign_cond = (a_msb == b_msb);
      OP_SUB:  sign_cond = (a_msb != b_msb);
      default: sign_cond = 1'b0;
    endcase
    return sign_cond && (sd_msb != a_msb);
  endfunction

endpackage

// File: rtl/bit6_addsub_accumulator_if.sv
// Operand stream in and chain-result stream out, both valid/ready.
// master = producer/consumer side, slave = accumulator side.
interface bit6_addsub_accumulator_if
  import bit6_addsub_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_op;
  logic             in_first;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cobo;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_op, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_cobo, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_data, in_op, in_first, in_last, out_ready,
    output in_ready, out_valid, out_result, out_cobo, out_ovf, out_count
  );
endinterface

// File: rtl/Bit6_Adder_Subtractor_DF.sv
// Combinational 6-bit adder/subtractor: m=0 a+b, m=1 a-b (two's complement).
// CoBo is carry-out on add and borrow (a < b unsigned) on subtract.
module Bit6_Adder_Subtractor_DF (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       m,
  output logic       CoBo,
  output logic [5:0] SD
);
  logic [6:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b ^ {6{m}}} + {6'd0, m};
  assign SD   = sum[5:0];
  // Raw carry on subtract means "no borrow", so invert it there.
  assign CoBo = sum[6] ^ m;
endmodule

// File: rtl/bit6_addsub_accumulator_ctrl.sv
// Chain controller around an external adder: result valid one cycle after the last beat.
// in_ready drops while a result is held; the result stays until out_ready, then one dead cycle.
module bit6_addsub_accumulator_ctrl
  import bit6_addsub_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  bit6_addsub_accumulator_if.slave   stream,
  output logic [WIDTH-1:0]           add_a_o,
  output logic [WIDTH-1:0]           add_b_o,
  output logic                       add_m_o,
  input  logic                       add_cobo_i,
  input  logic [WIDTH-1:0]           add_sd_i
);
  state_e           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cobo_q, cobo_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_cobo_q;
  logic             out_ovf_q;
  logic [CNT_W-1:0] out_count_q;

  logic             accept;
  logic             first_beat;

  assign add_a_o = acc_q;
  assign add_b_o = stream.in_data;
  assign add_m_o = stream.in_op;

  assign accept     = stream.in_valid & in_ready_q;
  assign first_beat = (state_q == IDLE) | stream.in_first;

  // Candidate next accumulator state; only committed on an accepted beat.
  always_comb begin
    acc_d  = acc_q;
    cobo_d = cobo_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (first_beat) begin
      acc_d  = stream.in_data;
      cobo_d = 1'b0;
      ovf_d  = 1'b0;
      cnt_d  = CNT_W'(1);
    end else begin
      acc_d  = add_sd_i;
      cobo_d = add_cobo_i;
      ovf_d  = ovf_q | ovf_step(stream.in_op, acc_q[WIDTH-1],
                                stream.in_data[WIDTH-1], add_sd_i[WIDTH-1]);
      cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cobo_q       <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cobo_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q  <= acc_d;
            cobo_q <= cobo_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            if (stream.in_last) begin
              state_q      <= HOLD;
              in_ready_q   <= 1'b0;
              out_valid_q  <= 1'b1;
              out_result_q <= acc_d;
              out_cobo_q   <= cobo_d;
              out_ovf_q    <= ovf_d;
              out_count_q  <= cnt_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (stream.out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign stream.in_ready   = in_ready_q;
  assign stream.out_valid  = out_valid_q;
  assign stream.out_result = out_result_q;
  assign stream.out_cobo   = out_cobo_q;
  assign stream.out_ovf    = out_ovf_q;
  assign stream.out_count  = out_count_q;
endmodule

// File: rtl/bit6_addsub_accumulator.sv
// Multi-operand add/sub calculator: chain controller wired to the 6-bit dataflow adder.
// Result valid one cycle after the last beat; input stalls while the result awaits out_ready.
module bit6_addsub_accumulator
  import bit6_addsub_accumulator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  bit6_addsub_accumulator_if.slave stream
);
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sd;
  logic             add_m;
  logic             add_cobo;

  bit6_addsub_accumulator_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .stream     (stream),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_m_o    (add_m),
    .add_cobo_i (add_cobo),
    .add_sd_i   (add_sd)
  );

  Bit6_Adder_Subtractor_DF u_adder (
    .a    (add_a),
    .b    (add_b),
    .m    (add_m),
    .CoBo (add_cobo),
    .SD   (add_sd)
  );
endmodule

// File: tb/tb_bit6_addsub_accumulator.sv
// Directed bench: one row per clock (inputs, then expected outputs after that edge).
module tb_bit6_addsub_accumulator;
  import bit6_addsub_accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bit6_addsub_accumulator_if #(.WIDTH(6), .CNT_W(6)) bus ();

  bit6_addsub_accumulator #(.WIDTH(6), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .stream (bus)
  );

  typedef struct {
    logic       v;
    logic [5:0] d;
    logic       op;
    logic       f;
    logic       l;
    logic       ordy;
    logic       ev;
    logic       erdy;
    logic       chk;
    logic [5:0] res;
    logic       cobo;
    logic       ovf;
    logic [5:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input int v, input int d, input int op, input int f,
                              input int l, input int ordy, input int ev, input int erdy,
                              input int chk, input int res, input int cobo, input int ovf,
                              input int cnt);
    vec_t r;
    r.v = 1'(v);     r.d = 6'(d);       r.op = 1'(op);    r.f = 1'(f);
    r.l = 1'(l);     r.ordy = 1'(ordy); r.ev = 1'(ev);    r.erdy = 1'(erdy);
    r.chk = 1'(chk); r.res = 6'(res);   r.cobo = 1'(cobo); r.ovf = 1'(ovf);
    r.cnt = 6'(cnt);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, compare outputs 1 time unit later.
  task automatic run_row(input string tag, input vec_t e);
    bus.in_valid  = e.v;
    bus.in_data   = e.d;
    bus.in_op     = e.op;
    bus.in_first  = e.f;
    bus.in_last   = e.l;
    bus.out_ready = e.ordy;
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, int'(bus.out_valid), int'(e.ev));
    check({tag, " in_ready"},  int'(bus.in_ready),  int'(e.erdy));
    if (e.chk) begin
      check({tag, " out_result"}, int'(bus.out_result), int'(e.res));
      check({tag, " out_cobo"},   int'(bus.out_cobo),   int'(e.cobo));
      check({tag, " out_ovf"},    int'(bus.out_ovf),    int'(e.ovf));
      check({tag, " out_count"},  int'(bus.out_count),  int'(e.cnt));
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = OP_ADD;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held for two edges.
    run_row("reset0", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    run_row("reset1", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    rst = 1'b0;

    // 23 + 20 = 43 overflows signed 6-bit.
    vecs.push_back(mk(1, 23, OP_ADD, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 20, OP_ADD, 0, 1, 0, 1, 0, 1, 43, 0, 1, 2));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0, 1, 0, 1, 1, 43, 0, 1, 2));
    // 53 - 10 = 43, no borrow, no overflow.
    vecs.push_back(mk(1, 53, OP_ADD, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 10, OP_SUB, 0, 1, 0, 1, 0, 1, 43, 0, 0, 2));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    // 56 + 42 = 34 (carry), idle bubble, 34 - 40 = 58 (borrow).
    vecs.push_back(mk(1, 56, OP_ADD, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 42, OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 40, OP_SUB, 0, 1, 0, 1, 0, 1, 58, 1, 0, 3));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    // Single-operand chain under backpressure; HOLD ignores in_valid.
    vecs.push_back(mk(1, 12, OP_ADD, 1, 1, 0, 1, 0, 1, 12, 0, 0, 1));
    vecs.push_back(mk(1, 7, OP_SUB, 1, 1, 0, 1, 0, 1, 12, 0, 0, 1));
    vecs.push_back(mk(1, 7, OP_SUB, 1, 1, 0, 1, 0, 1, 12, 0, 0, 1));
    vecs.push_back(mk(1, 7, OP_SUB, 1, 1, 0, 1, 0, 1, 12, 0, 0, 1));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0, 1, 0, 1, 1, 12, 0, 0, 1));
    // 30 (op ignored), +15 overflows, then in_first restarts the chain with 20.
    vecs.push_back(mk(1, 30, OP_SUB, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 15, OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 20, OP_ADD, 1, 1, 0, 1, 0, 1, 20, 0, 0, 1));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    // In IDLE a beat without in_first still opens a chain: 5 - 9 = 60, borrow.
    vecs.push_back(mk(1, 5, OP_SUB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, OP_SUB, 0, 1, 0, 1, 0, 1, 60, 1, 0, 2));
    vecs.push_back(mk(0, 0, OP_ADD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));

    foreach (vecs[i]) run_row($sformatf("row%0d", i), vecs[i]);

    // 70 beats of +1: result wraps to 6, count saturates at 63, overflow sticks.
    run_row("sat_first", mk(1, 1, OP_ADD, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 68; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 6'd1; bus.in_op = OP_ADD;
      bus.in_first = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
    end
    run_row("sat_last", mk(1, 1, OP_ADD, 0, 1, 0, 1, 0, 1, 6, 0, 1, 63));
    run_row("sat_ack",  mk(0, 0, OP_ADD, 0, 0, 1, 0, 1, 1, 6, 0, 1, 63));

    // Reset mid-chain after 23, +10: chain discarded and result registers cleared.
    run_row("mid_a", mk(1, 23, OP_ADD, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run_row("mid_b", mk(1, 10, OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    rst = 1'b1;
    run_row("mid_rst", mk(0, 0, OP_ADD, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    rst = 1'b0;
    run_row("mid_idle0", mk(0, 0, OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run_row("mid_idle1", mk(0, 0, OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Continuation beat after reset must start a fresh chain, not add to 33.
    run_row("post_rst", mk(1, 4, OP_SUB, 0, 1, 0, 1, 0, 1, 4, 0, 0, 1));
    // Reset while holding a result drops it without a handshake.
    rst = 1'b1;
    run_row("hold_rst", mk(0, 0, OP_ADD, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    rst = 1'b0;
    run_row("hold_idle", mk(0, 0, OP_ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
